// File: rtl/fixed_pkg.sv
// Shared constants and types for the 17-bit sign-magnitude fixed-point blocks
// (1 sign, 8 integer, 8 fraction bits).
package fixed_pkg;

  localparam int NUM_WIDTH  = 16;
  localparam int FRAC_WIDTH = 8;
  localparam int FIX_WIDTH  = NUM_WIDTH + 1;
  localparam int SIGN_BIT   = NUM_WIDTH;

  localparam logic [FIX_WIDTH-1:0] FIX_ONE = FIX_WIDTH'(1 << FRAC_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/fixed_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module fixed_div_step #(
  parameter int DIV_WIDTH = fixed_pkg::NUM_WIDTH
) (
  input  logic [DIV_WIDTH:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH:0]   rem_out,
  output logic                 q_bit
);

  logic [DIV_WIDTH:0] shifted;
  logic [DIV_WIDTH:0] diff;

  // A set top bit of rem_in would push the shifted value past any divisor,
  // and the modular difference is still exact because the result is < divisor.
  assign shifted = {rem_in[DIV_WIDTH-1:0], bit_in};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = rem_in[DIV_WIDTH] | (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/fixed_div.sv
// Iterative sign-magnitude fixed-point divider, one quotient bit per cycle,
// with valid/ready handshakes and clip / divide-by-zero flags.
module fixed_div #(
  parameter int NUM_WIDTH  = fixed_pkg::NUM_WIDTH,
  parameter int FRAC_WIDTH = fixed_pkg::FRAC_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_WIDTH:0] a,
  input  logic [NUM_WIDTH:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_WIDTH:0] q,
  output logic               clip_int,
  output logic               clip_frac,
  output logic               div_zero
);
  import fixed_pkg::*;

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // DIV   | one restoring step per cycle, or divide-by-zero short cut
  // DONE  | result held until the consumer takes it

  localparam int QUOT_WIDTH = NUM_WIDTH + FRAC_WIDTH;
  localparam int CNT_WIDTH  = $clog2(QUOT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(QUOT_WIDTH - 1);

  div_state_e state, state_nxt;

  logic                  sign_r;
  logic [QUOT_WIDTH-1:0] dividend;
  logic [QUOT_WIDTH-1:0] quot;
  logic [QUOT_WIDTH-1:0] quot_nxt;
  logic [NUM_WIDTH-1:0]  divisor;
  logic [NUM_WIDTH:0]    rem;
  logic [NUM_WIDTH:0]    step_rem;
  logic                  step_bit;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  accept;
  logic                  release_out;
  logic                  divisor_zero;

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign accept       = in_valid & in_ready;
  assign release_out  = out_valid & out_ready;
  assign divisor_zero = (divisor == '0);

  fixed_div_step #(
    .DIV_WIDTH(NUM_WIDTH)
  ) u_step (
    .rem_in (rem),
    .bit_in (dividend[QUOT_WIDTH-1]),
    .divisor(divisor),
    .rem_out(step_rem),
    .q_bit  (step_bit)
  );

  assign quot_nxt = {quot[QUOT_WIDTH-2:0], step_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A zero divisor is detected on the first DIV cycle, so it reports one
  // cycle after acceptance instead of running all the steps.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DIV;
      DIV:     if (divisor_zero || (cnt == '0)) state_nxt = DONE;
      DONE:    if (release_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r    <= 1'b0;
      dividend  <= '0;
      divisor   <= '0;
      rem       <= '0;
      quot      <= '0;
      cnt       <= '0;
      q         <= '0;
      clip_int  <= 1'b0;
      clip_frac <= 1'b0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      sign_r   <= a[NUM_WIDTH] ^ b[NUM_WIDTH];
      dividend <= {a[NUM_WIDTH-1:0], {FRAC_WIDTH{1'b0}}};
      divisor  <= b[NUM_WIDTH-1:0];
      rem      <= '0;
      quot     <= '0;
      cnt      <= LAST_STEP;
    end else if (state == DIV) begin
      if (divisor_zero) begin
        q         <= {sign_r, {NUM_WIDTH{1'b1}}};
        div_zero  <= 1'b1;
        clip_int  <= 1'b1;
        clip_frac <= 1'b0;
      end else begin
        dividend <= {dividend[QUOT_WIDTH-2:0], 1'b0};
        rem      <= step_rem;
        quot     <= quot_nxt;
        cnt      <= cnt - 1'b1;
        if (cnt == '0) begin
          // Magnitude wraps by truncation; anything above NUM_WIDTH is overflow.
          q         <= {sign_r, quot_nxt[NUM_WIDTH-1:0]};
          clip_int  <= quot[QUOT_WIDTH-1] | (|quot_nxt[QUOT_WIDTH-1:NUM_WIDTH]);
          clip_frac <= |step_rem;
          div_zero  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_div.sv
// Self-checking bench for fixed_div: directed vector table, handshake corner
// sequences, and randomized operands against an arithmetic reference model.
module tb_fixed_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] a = '0;
  logic [16:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] q;
  logic        clip_int;
  logic        clip_frac;
  logic        div_zero;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_div dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .clip_int (clip_int),
    .clip_frac(clip_frac),
    .div_zero (div_zero)
  );

  typedef struct {
    logic [16:0] a;
    logic [16:0] b;
    logic [16:0] q;
    logic        ci;
    logic        cf;
    logic        dz;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Result packed as {div_zero, clip_int, clip_frac, q}.
  function automatic logic [19:0] model(input logic [16:0] ma, input logic [16:0] mb);
    logic        sign;
    int unsigned num, den, quo, rm;
    sign = ma[16] ^ mb[16];
    den  = 32'(mb[15:0]);
    if (den == 0) return {1'b1, 1'b1, 1'b0, sign, 16'hFFFF};
    num = 32'(ma[15:0]) * 256;
    quo = num / den;
    rm  = num % den;
    return {1'b0, (quo >= 32'h10000), (rm != 0), sign, quo[15:0]};
  endfunction

  task automatic run_op(input logic [16:0] ta, input logic [16:0] tb, input int hold,
                        output logic [19:0] res, output int lat);
    int n;
    @(negedge clk);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 17'($urandom);
    b = 17'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
    res = {div_zero, clip_int, clip_frac, q};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("hold_result", 32'({div_zero, clip_int, clip_frac, q}), 32'(res));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_keep", 32'({div_zero, clip_int, clip_frac, q}), 32'(res));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] res;
    logic [19:0] exp;
    logic [16:0] ra, rb;
    int          lat;
    int          k;
    int          acc[3];
    int          seen;

    vecs[0] = '{17'h00300, 17'h00180, 17'h00200, 1'b0, 1'b0, 1'b0, 24, 5};
    vecs[1] = '{17'h10100, 17'h00300, 17'h10055, 1'b0, 1'b1, 1'b0, 24, 0};
    vecs[2] = '{17'h08000, 17'h00080, 17'h00000, 1'b1, 1'b0, 1'b0, 24, 1};
    vecs[3] = '{17'h00100, 17'h10000, 17'h1FFFF, 1'b1, 1'b0, 1'b1, 1, 2};
    vecs[4] = '{17'h00100, 17'h00100, 17'h00100, 1'b0, 1'b0, 1'b0, 24, 0};
    vecs[5] = '{17'h1FFFF, 17'h00001, 17'h1FF00, 1'b1, 1'b0, 1'b0, 24, 0};
    vecs[6] = '{17'h10000, 17'h10100, 17'h00000, 1'b0, 1'b0, 1'b0, 24, 0};
    vecs[7] = '{17'h00100, 17'h00300, 17'h00055, 1'b0, 1'b1, 1'b0, 24, 3};

    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'({div_zero, clip_int, clip_frac, q}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].hold, res, lat);
      check($sformatf("vec%0d_q", i), 32'(res[16:0]), 32'(vecs[i].q));
      check($sformatf("vec%0d_flags", i), 32'(res[19:17]),
            32'({vecs[i].dz, vecs[i].ci, vecs[i].cf}));
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Back-to-back throughput with in_valid and out_ready held high.
    @(negedge clk);
    a = 17'h00300;
    b = 17'h00180;
    in_valid = 1'b1;
    out_ready = 1'b1;
    k = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    for (int n = 0; n < 200 && k < 3; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc[k] = cyc;
        k++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_accepts", k, 3);
    check("b2b_interval0", acc[1] - acc[0], 26);
    check("b2b_interval1", acc[2] - acc[1], 26);
    seen = 0;
    for (int n = 0; n < 40 && seen == 0; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        check("b2b_q", 32'(q), 32'h00200);
      end
    end
    check("b2b_result_seen", seen, 1);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a division.
    @(negedge clk);
    a = 17'h00300;
    b = 17'h00180;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_result", 32'({div_zero, clip_int, clip_frac, q}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midreset_no_result", seen, 0);
    run_op(17'h10100, 17'h00300, 0, res, lat);
    check("post_reset_result", 32'(res), 32'({1'b0, 1'b0, 1'b1, 17'h10055}));
    check("post_reset_latency", lat, 24);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = 17'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = {1'($urandom), 16'h0000};
        1, 2:    rb = {1'($urandom), 8'h00, 8'($urandom)};
        3, 4, 5: rb = {1'($urandom), 4'h0, 12'($urandom)};
        default: rb = 17'($urandom);
      endcase
      exp = model(ra, rb);
      run_op(ra, rb, $urandom_range(0, 2), res, lat);
      check($sformatf("rand%0d a=%h b=%h", i, ra, rb), 32'(res), 32'(exp));
      check($sformatf("rand%0d_latency", i), lat, exp[19] ? 1 : 24);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
